// File: rtl/fp16_add_sched.sv
// fp16_add_sched: round-robin front-end that shares one pipelined fp16 adder
// among NUM_REQ requesters. At most one operand pair is accepted per cycle,
// registered onto the adder inputs, and its requester ID rides a tag pipe
// alongside the adder so every result comes back labelled with its owner.
//
// Optional feature: define FP16_SCHED_SUB_EN to honour req_sub_i (the sign of
// operand B is flipped on accept so the requester gets a-b). Without the macro
// req_sub_i is ignored.
//
// Ports:
//   clk_i, rst_n_i      clock, asynchronous active-low reset
//   req_valid_i/ready_o per-requester handshake (ready is one-hot or zero)
//   req_a_i, req_b_i    packed operands, requester i at [16*i+15:16*i]
//   req_sub_i           per-requester subtract flag (optional feature)
//   add_a_o, add_b_o    registered operands to the shared adder
//   add_result_i        adder output, ADD_LAT cycles after add_a_o/add_b_o
//   rsp_valid_o/id_o    result valid and owning requester
//   rsp_data_o          add_result_i passed straight through
//   inflight_o, busy_o  issued-but-not-returned count, and (count != 0)
module fp16_add_sched #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int ADD_LAT = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [NUM_REQ-1:0]    req_valid_i,
  output logic [NUM_REQ-1:0]    req_ready_o,
  input  logic [16*NUM_REQ-1:0] req_a_i,
  input  logic [16*NUM_REQ-1:0] req_b_i,
  input  logic [NUM_REQ-1:0]    req_sub_i,
  output logic [15:0]           add_a_o,
  output logic [15:0]           add_b_o,
  input  logic [15:0]           add_result_i,
  output logic                  rsp_valid_o,
  output logic [ID_W-1:0]       rsp_id_o,
  output logic [15:0]           rsp_data_o,
  output logic [ID_W+1:0]       inflight_o,
  output logic                  busy_o
);

  logic [NUM_REQ-1:0][15:0] a_vec, b_vec;
  assign a_vec = req_a_i;
  assign b_vec = req_b_i;

  logic [ID_W-1:0]            rr_ptr_q, rr_ptr_d;
  logic [15:0]                add_a_q, add_a_d, add_b_q, add_b_d;
  logic [ADD_LAT:0]           vld_pipe_q, vld_pipe_d;
  logic [ADD_LAT:0][ID_W-1:0] id_pipe_q, id_pipe_d;
  logic [ID_W+1:0]            inflight_q, inflight_d;
  logic                       busy_q;

  logic                       gnt_vld;
  logic [ID_W-1:0]            gnt_id;
  logic [2*NUM_REQ-1:0]       vld_dbl;
  logic [NUM_REQ-1:0]         vld_rot;
  logic [ID_W:0]              gnt_sum;
  logic [15:0]                b_eff;

  // Rotate the valid vector so bit k is requester (rr_ptr+k) mod NUM_REQ;
  // the first set bit in rotated order wins.
  assign vld_dbl = {req_valid_i, req_valid_i} >> rr_ptr_q;
  assign vld_rot = vld_dbl[NUM_REQ-1:0];

  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    gnt_sum = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!gnt_vld && vld_rot[k]) begin
        gnt_vld = 1'b1;
        gnt_sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
        if (gnt_sum >= (ID_W+1)'(NUM_REQ)) gnt_sum = gnt_sum - (ID_W+1)'(NUM_REQ);
        gnt_id  = gnt_sum[ID_W-1:0];
      end
    end
  end

  assign req_ready_o = gnt_vld ? (NUM_REQ'(1) << gnt_id) : '0;

`ifdef FP16_SCHED_SUB_EN
  // Flipping B's sign turns the shared adder into a subtractor; a NaN B stays
  // NaN, so the adder still returns its quiet NaN.
  assign b_eff = {b_vec[gnt_id][15] ^ req_sub_i[gnt_id], b_vec[gnt_id][14:0]};
`else
  logic unused_sub;
  assign unused_sub = ^req_sub_i;
  assign b_eff      = b_vec[gnt_id];
`endif

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    add_a_d    = 16'h0000;
    add_b_d    = 16'h0000;
    if (gnt_vld) begin
      rr_ptr_d = (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + 1'b1;
      add_a_d  = a_vec[gnt_id];
      add_b_d  = b_eff;
    end
    // Tag pipe never stalls: the adder cannot be held, so neither can we.
    vld_pipe_d = {vld_pipe_q[ADD_LAT-1:0], gnt_vld};
    id_pipe_d  = {id_pipe_q[ADD_LAT-1:0], (gnt_vld ? gnt_id : ID_W'(0))};
    // Accept and return in the same cycle cancel out.
    inflight_d = inflight_q;
    case ({gnt_vld, vld_pipe_q[ADD_LAT]})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rr_ptr_q   <= '0;
      add_a_q    <= 16'h0000;
      add_b_q    <= 16'h0000;
      vld_pipe_q <= '0;
      id_pipe_q  <= '0;
      inflight_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      add_a_q    <= add_a_d;
      add_b_q    <= add_b_d;
      vld_pipe_q <= vld_pipe_d;
      id_pipe_q  <= id_pipe_d;
      inflight_q <= inflight_d;
      busy_q     <= (inflight_d != '0);
    end
  end

  assign add_a_o     = add_a_q;
  assign add_b_o     = add_b_q;
  assign rsp_valid_o = vld_pipe_q[ADD_LAT];
  assign rsp_id_o    = id_pipe_q[ADD_LAT];
  assign rsp_data_o  = add_result_i;
  assign inflight_o  = inflight_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_fp16_add_sched.sv
// Bench for fp16_add_sched: directed and randomized requester traffic checked
// against a scoreboard model of the round-robin rule and the fixed latency.
// A behavioural fp16 adder (ADD_LAT register stages) sits on the adder port.
module tb_fp16_add_sched;
  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int LAT = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid, req_ready, req_sub;
  logic [16*N-1:0] req_a, req_b;
  logic [15:0]     add_a, add_b, add_result, rsp_data;
  logic            rsp_valid, busy;
  logic [IDW-1:0]  rsp_id;
  logic [IDW+1:0]  inflight;

  always #5 clk = ~clk;

  fp16_add_sched #(.NUM_REQ(N), .ID_W(IDW), .ADD_LAT(LAT)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_a_i(req_a), .req_b_i(req_b), .req_sub_i(req_sub),
    .add_a_o(add_a), .add_b_o(add_b), .add_result_i(add_result),
    .rsp_valid_o(rsp_valid), .rsp_id_o(rsp_id), .rsp_data_o(rsp_data),
    .inflight_o(inflight), .busy_o(busy));

  // fp16 <-> real for normal numbers and zero (all bench operands are small integers)
  function automatic real h2r(input logic [15:0] h);
    real m; int e;
    if (h[14:0] == 15'd0) return 0.0;
    m = 1.0 + real'(h[9:0]) / 1024.0;
    e = int'(h[14:10]) - 15;
    for (int i = 0; i < e; i++) m = m * 2.0;
    for (int i = 0; i > e; i--) m = m / 2.0;
    return h[15] ? -m : m;
  endfunction

  function automatic logic [15:0] r2h(input real x);
    real m; int e; logic s;
    if (x == 0.0) return 16'h0000;
    s = (x < 0.0);
    m = s ? -x : x;
    e = 0;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    return {s, 5'(e + 15), 10'($rtoi((m - 1.0) * 1024.0))};
  endfunction

  // Behavioural shared adder: ADD_LAT cycles from operands to result
  logic [15:0] ap [LAT];
  always @(posedge clk) begin
    ap[0] <= r2h(h2r(add_a) + h2r(add_b));
    for (int i = 1; i < LAT; i++) ap[i] <= ap[i-1];
  end
  assign add_result = ap[LAT-1];

  // Requester state and reference model
  typedef struct { int id; logic [15:0] data; int due; } rsp_t;
  rsp_t        q[$];
  logic [N-1:0] pv;
  logic [15:0] pa [N];
  logic [15:0] pb [N];
  logic        ps [N];
  int          waitc [N];
  int          m_ptr, m_infl, cyc;
  int          checks, errors;

  function automatic logic [15:0] rnd_op();
    int v; real r;
    v = $urandom_range(15);
    r = real'(v);
    if ($urandom_range(1) == 1) r = -r;
    return r2h(r);
  endfunction

  function automatic logic [15:0] exp_b(input int i);
`ifdef FP16_SCHED_SUB_EN
    return {pb[i][15] ^ ps[i], pb[i][14:0]};
`else
    return pb[i];
`endif
  endfunction

  function automatic logic [15:0] exp_sum(input int i);
`ifdef FP16_SCHED_SUB_EN
    return r2h(h2r(pa[i]) + (ps[i] ? -h2r(pb[i]) : h2r(pb[i])));
`else
    return r2h(h2r(pa[i]) + h2r(pb[i]));
`endif
  endfunction

  // Round-robin rule: first pending requester at or after the pointer
  function automatic int exp_grant();
    for (int k = 0; k < N; k++)
      if (pv[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic apply();
    req_valid = pv;
    for (int i = 0; i < N; i++) begin
      req_a[16*i +: 16] = pa[i];
      req_b[16*i +: 16] = pb[i];
      req_sub[i]        = ps[i];
    end
  endtask

  // Advance one clock and update the model with what the edge should do
  task automatic edge_update(input int g, output logic [15:0] ea, output logic [15:0] eb);
    logic [15:0] s;
    s = (g >= 0) ? exp_sum(g) : 16'h0000;
    @(posedge clk);
    cyc++;
    if (q.size() > 0 && q[0].due == cyc - 1) begin
      void'(q.pop_front());
      m_infl--;
    end
    for (int i = 0; i < N; i++) if (pv[i] && i != g) waitc[i]++;
    if (g >= 0) begin
      q.push_back('{g, s, cyc + LAT});
      m_ptr  = (g + 1) % N;
      m_infl++;
      ea     = pa[g];
      eb     = exp_b(g);
      pv[g]  = 1'b0;
    end else begin
      ea = 16'h0000;
      eb = 16'h0000;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pv = '0;
    for (int i = 0; i < N; i++) begin pa[i] = 16'h0; pb[i] = 16'h0; ps[i] = 1'b0; waitc[i] = 0; end
    apply();
    m_ptr = 0; m_infl = 0; cyc = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (add_a !== 16'h0 || add_b !== 16'h0) begin errors++; $display("FAIL reset_operands: got %h/%h want 0000/0000", add_a, add_b); end
    checks++; if (rsp_valid !== 1'b0 || rsp_id !== '0) begin errors++; $display("FAIL reset_rsp: got v=%b id=%0d want 0/0", rsp_valid, rsp_id); end
    checks++; if (inflight !== '0 || busy !== 1'b0) begin errors++; $display("FAIL reset_inflight: got %0d busy=%b want 0/0", inflight, busy); end
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    rst_n = 1'b1;
  endtask

  task automatic test_single_op();
    int          infl_exp [4] = '{1, 1, 1, 0};
    logic [15:0] ea, eb;
    pv[0] = 1'b1; pa[0] = 16'h3C00; pb[0] = 16'h4000; ps[0] = 1'b0;
    apply(); #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b want 0001", req_ready); end
    edge_update(0, ea, eb);
    checks++; if (add_a !== 16'h3C00 || add_b !== 16'h4000) begin errors++; $display("FAIL single_operands: got %h/%h want 3c00/4000", add_a, add_b); end
    for (int k = 1; k <= 4; k++) begin
      apply(); #1;
      checks++; if (rsp_valid !== (k == 3)) begin errors++; $display("FAIL single_rsp_valid c%0d: got %b want %b", k, rsp_valid, (k == 3)); end
      if (k == 3) begin
        checks++; if (rsp_id !== 2'd0 || rsp_data !== 16'h4200) begin errors++; $display("FAIL single_rsp: got id=%0d data=%h want 0/4200", rsp_id, rsp_data); end
      end
      checks++; if (inflight !== 4'(infl_exp[k-1])) begin errors++; $display("FAIL single_inflight c%0d: got %0d want %0d", k, inflight, infl_exp[k-1]); end
      edge_update(-1, ea, eb);
    end
  endtask

  task automatic test_sub();
    logic [15:0] ea, eb;
`ifdef FP16_SCHED_SUB_EN
    logic [15:0] want_b = 16'hBC00, want_r = 16'h4000;
`else
    logic [15:0] want_b = 16'h3C00, want_r = 16'h4400;
`endif
    pv[1] = 1'b1; pa[1] = 16'h4200; pb[1] = 16'h3C00; ps[1] = 1'b1;
    apply(); #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL sub_ready: got %b want 0010", req_ready); end
    edge_update(1, ea, eb);
    checks++; if (add_a !== 16'h4200 || add_b !== want_b) begin errors++; $display("FAIL sub_operands: got %h/%h want 4200/%h", add_a, add_b, want_b); end
    for (int k = 1; k <= 3; k++) begin
      apply(); #1;
      if (k == 3) begin
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== want_r) begin errors++; $display("FAIL sub_rsp: got v=%b id=%0d data=%h want 1/1/%h", rsp_valid, rsp_id, rsp_data, want_r); end
      end
      edge_update(-1, ea, eb);
    end
  endtask

  // mode 0: all requesters keep re-raising; 1: only req2/req3; 2: no new raises
  // (pending ones drain); 3: random raises
  task automatic test_stream(input string name, input int mode, input int ncyc);
    int          g;
    logic [N-1:0] er;
    logic        ev;
    logic [15:0] ea, eb;
    for (int c = 0; c < ncyc; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pv[i]) begin
          bit raise;
          case (mode)
            0:       raise = 1'b1;
            1:       raise = (i >= 2);
            3:       raise = ($urandom_range(1) == 1);
            default: raise = 1'b0;
          endcase
          if (raise) begin
            pv[i] = 1'b1; pa[i] = rnd_op(); pb[i] = rnd_op(); ps[i] = ($urandom_range(1) == 1); waitc[i] = 0;
          end
        end
      end
      apply(); #1;
      g  = exp_grant();
      er = (g < 0) ? '0 : (N'(1) << g);
      ev = (q.size() > 0 && q[0].due == cyc);
      checks++; if (req_ready !== er) begin errors++; $display("FAIL %s_ready c%0d: got %b want %b", name, cyc, req_ready, er); end
      checks++; if (rsp_valid !== ev) begin errors++; $display("FAIL %s_rsp_valid c%0d: got %b want %b", name, cyc, rsp_valid, ev); end
      if (ev) begin
        checks++; if (rsp_id !== IDW'(q[0].id) || rsp_data !== q[0].data) begin errors++; $display("FAIL %s_rsp c%0d: got id=%0d data=%h want %0d/%h", name, cyc, rsp_id, rsp_data, q[0].id, q[0].data); end
      end
      checks++; if (inflight !== (IDW+2)'(m_infl) || busy !== (m_infl != 0)) begin errors++; $display("FAIL %s_inflight c%0d: got %0d busy=%b want %0d", name, cyc, inflight, busy, m_infl); end
      for (int i = 0; i < N; i++) if (pv[i]) begin
        checks++; if (waitc[i] >= N) begin errors++; $display("FAIL %s_fairness req%0d: waited %0d want <%0d", name, i, waitc[i], N); end
      end
      edge_update(g, ea, eb);
      checks++; if (add_a !== ea || add_b !== eb) begin errors++; $display("FAIL %s_operands c%0d: got %h/%h want %h/%h", name, cyc, add_a, add_b, ea, eb); end
    end
  endtask

  task automatic test_reset_midop();
    test_stream("pre_reset", 0, 2);
    checks++; if (inflight !== 4'd2) begin errors++; $display("FAIL midop_inflight: got %0d want 2", inflight); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (add_a !== 16'h0 || add_b !== 16'h0) begin errors++; $display("FAIL midop_operands: got %h/%h want 0000/0000", add_a, add_b); end
    checks++; if (rsp_valid !== 1'b0 || inflight !== '0 || busy !== 1'b0) begin errors++; $display("FAIL midop_clear: got v=%b infl=%0d busy=%b want 0/0/0", rsp_valid, inflight, busy); end
    q.delete(); m_ptr = 0; m_infl = 0; pv = '0;
    apply();
    @(posedge clk); cyc++;
    #1 rst_n = 1'b1;
    test_stream("post_reset_idle", 2, 5);
    test_stream("post_reset_all", 0, 4);
    test_stream("post_reset_drain", 2, 8);
  endtask

  initial begin
    checks = 0; errors = 0;
    test_reset();
    test_single_op();
    test_stream("all_valid", 0, 8);
    test_stream("idle", 2, 10);
    test_stream("two_req", 1, 6);
    test_stream("drain", 2, 6);
    test_sub();
    test_stream("random", 3, 200);
    test_stream("final_drain", 2, 8);
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp16_add_sched.md
Name: fp16_add_sched

Overview:
- Round-robin scheduler that shares one pipelined fp16_add instance among NUM_REQ requesters.
- Accepts at most one operand pair per cycle, registers it onto the adder inputs, and tracks the requester ID through the adder latency.
- Returns each result with its ID.
- Sits between the vector/accumulate front-ends and the single shared half-precision adder.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of requester ID; must satisfy 2**ID_W >= NUM_REQ.
- ADD_LAT, 2, latency of the attached adder in cycles, from add_a/add_b valid to add_result valid.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester operand-pair valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  in  16*NUM_REQ  operand A; requester i occupies bits [16*i+15:16*i].
- req_b  in  16*NUM_REQ  operand B; same packing as req_a.
- req_sub  in  NUM_REQ  per-requester subtract flag (used only with the optional feature).
- add_a  out  16  registered operand A to the adder.
- add_b  out  16  registered operand B to the adder.
- add_result  in  16  adder output.
- rsp_valid  out  1  result valid this cycle.
- rsp_id  out  ID_W  requester ID owning the result.
- rsp_data  out  16  result value; equals add_result when rsp_valid=1.
- inflight  out  ID_W+2  number of issued, not yet returned operations.
- busy  out  1  asserted when inflight != 0.

Behaviour:
- Reset (async assert, sync release): rr_ptr=0; add_a=add_b=0x0000; tag pipe cleared; rsp_valid=0; rsp_id=0; inflight=0; busy=0.
- Reset mid-operation: all in-flight ops are discarded. No rsp_valid is produced for them after release.
- Arbitration (combinational):
  - Search req_valid starting at index rr_ptr, wrapping modulo NUM_REQ.
  - The first asserted index g gets req_ready[g]=1; all other ready bits are 0.
  - No req_valid asserted -> req_ready all 0.
- Accept: a handshake occurs when req_valid[g]&req_ready[g] at a rising edge. On that edge:
  - add_a <= req_a[g]; add_b <= req_b[g].
  - Tag stage 0 <= {1, g}.
  - rr_ptr <= (g+1) mod NUM_REQ. Wrap from NUM_REQ-1 goes to 0.
- No accept: rr_ptr holds; add_a/add_b <= 0x0000; tag stage 0 <= {0, 0}.
- Tag pipe: ADD_LAT further stages of {valid, id}, shifting every cycle with no stall. The adder cannot stall, so results carry no backpressure.
- Latency: handshake at edge T -> operands on add_a/add_b during cycle T+1 -> rsp_valid=1, rsp_id=g, rsp_data=add_result during cycle T+1+ADD_LAT.
  - rsp_valid/rsp_id come from the last tag stage.
  - rsp_data is add_result passed through combinationally; it is don't-care when rsp_valid=0.
- Throughput: one op per cycle sustained. Responses return in issue order.
- Fairness: with all requesters continuously valid, grants follow 0,1,2,3,0,...
  - A requester is granted within NUM_REQ cycles of raising req_valid.
- Requester rules:
  - Must hold req_valid and operands stable until ready.
  - The scheduler never grants a requester whose req_valid is low.
- inflight:
  - +1 on accept, -1 when the last tag stage is valid.
  - Simultaneous accept and return -> unchanged.
  - Maximum value is ADD_LAT+1, which never overflows.
- busy = (inflight != 0), registered together with inflight.

Optional Feature:
- Macro FP16_SCHED_SUB_EN.
- Defined: on accept, add_b <= {req_b[g][15]^req_sub[g], req_b[g][14:0]}, so the requester obtains a-b.
  - Subtracting a NaN operand still yields the adder's quiet NaN.
- Undefined: req_sub is ignored and add_b <= req_b[g] unchanged.

Test Plan:
- Single op: req0 a=0x3C00 (1.0), b=0x4000 (2.0) valid at edge 0, adder model returns 0x4200 -> add_a/add_b = 0x3C00/0x4000 in cycle 1; rsp_valid=1, rsp_id=0, rsp_data=0x4200 in cycle 3 only; inflight 1,1,1,0.
- All four requesters valid continuously for 8 cycles -> grant order 0,1,2,3,0,1,2,3; rsp_id sequence identical and delayed 3 cycles; inflight saturates at 3.
- Only req2 and req3 valid, rr_ptr=0 -> req2 granted first, then req3, then req2; req0/req1 ready never asserted.
- Reset asserted asynchronously mid-cycle with 2 ops in flight -> outputs clear immediately; no rsp_valid after release; rr_ptr=0.
- FP16_SCHED_SUB_EN defined: req1 a=0x4200 (3.0), b=0x3C00, sub=1 -> add_b=0xBC00, rsp_data=0x4000 (2.0), rsp_id=1. Undefined: add_b=0x3C00, rsp_data=0x4400 (4.0).
- Idle: no req_valid for 5 cycles -> add_a=add_b=0x0000, rsp_valid=0, busy=0, rr_ptr unchanged.
